stepper_pulse_gen: RTL and testbench
====================================

Name: stepper_pulse_gen

Overview:
Downstream consumer of the command converter's 16-bit word {direction, freq[9:0], lapse[4:0]}. It turns one command into a timed stepper-driver step/dir/enable sequence: step pulses at `freq` steps/s for `lapse`×0.1 s, with direction set up before the first step. There is one instance per wheel; instances are driven in parallel from the same command word.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz; also the phase-accumulator modulus.
STEP_HIGH_CYC, 1000, step pulse high width in cycles. Must be < CLK_HZ/1023.
DIR_SETUP_CYC, 500, cycles dir_o is held stable before the first step. Must be ≥ 1.
(derived) TICK_CYC = CLK_HZ/10, cycles per lapse unit.

Ports:
clk_rx  in  1  system clock
rst_clk_rx  in  1  reset, asynchronous, active-high
cmd_in  in  16  [15]=dir (1 fwd), [14:5]=freq steps/s, [4:0]=lapse in 0.1 s units; level-held, 0 = no command
step_o  out  1  step pulse to driver
dir_o  out  1  direction to driver
motor_en_o  out  1  driver enable, high in SETUP/RUN
busy_o  out  1  high in SETUP/RUN
done_o  out  1  one-cycle pulse on natural completion
step_cnt_o  out  16  steps emitted for current/last command, saturating at 0xFFFF
overrun_o  out  1  sticky: a step was dropped because step_o was still high

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, armed=1, all counters and accumulator 0.
- Valid command: cmd_in[14:5]≠0 and cmd_in[4:0]≠0.
- armed flag: set whenever cmd_in==0; cleared on accept.
- Accept condition: valid && (armed || cmd_in≠latched). This prevents re-running a command still held after completion.
- On accept:
  - latch cmd_in.
  - dir_o ← cmd_in[15] on the next edge.
  - clear step_cnt_o and overrun_o.
  - go to SETUP.
- FSM states: IDLE, SETUP, RUN.
- IDLE → SETUP: on accept.
- SETUP:
  - motor_en_o=1, busy_o=1.
  - The setup counter advances only while step_o=0.
  - After DIR_SETUP_CYC counted cycles → RUN.
- RUN:
  - Entry cycle: step_o rises (first step), accumulator ←0, duration counter ←0.
  - Each subsequent cycle: acc ← acc+freq. If the sum ≥ CLK_HZ, subtract CLK_HZ and raise a step event.
  - Accumulator width is ceil(log2(2·CLK_HZ)).
  - Duration: cycle prescaler counts to TICK_CYC; a 5-bit tick counter compares against latched lapse.
  - RUN lasts exactly lapse×TICK_CYC cycles, counted from the entry cycle.
  - On the terminal cycle the FSM goes to IDLE and done_o pulses for 1 cycle. A step event in that same cycle is suppressed; termination has priority.
- Step pulse:
  - Independent counter holds step_o high for exactly STEP_HIGH_CYC cycles.
  - step_cnt_o increments on each rising edge of step_o.
  - A step event while step_o=1 is dropped (not queued) and sets overrun_o.
  - An in-progress pulse always completes its full width, even after leaving RUN.
- In SETUP/RUN, a valid cmd_in≠latched: re-latch, update dir_o, clear step_cnt_o and overrun_o, go to SETUP. No done_o is issued.
- In SETUP/RUN, cmd_in==0 (abort): go to IDLE next cycle, no done_o; step_cnt_o retains its value.
- Simultaneous abort/re-latch and termination: the cmd_in action wins; no done_o.
- In SETUP/RUN, invalid nonzero cmd_in (freq=0 or lapse=0): treated as abort.
- motor_en_o and busy_o drop in the same cycle the FSM enters IDLE.
- Expected step count when CLK_HZ divides evenly: lapse×freq/10.

Decomposition:
- Shared package:
  - command field slices (CMD_DIR_BIT=15, CMD_FREQ_MSB/LSB=14/5, CMD_LAPSE_MSB/LSB=4/0).
  - FSM state encoding.
  - LAPSE_UNIT_DIV=10.
  - The same slice constants are reused by the converter.
- One natural sub-module: step_pulse_stretch, a retriggerable-blocked fixed-width pulse with drop flag.
- The phase accumulator and FSM stay in the top module.

Test Plan:
Bench config for all scenarios: CLK_HZ=10000, STEP_HIGH_CYC=2, DIR_SETUP_CYC=4.
1. Basic run: reset, then cmd_in={1,100,10} held → dir_o=1 one cycle after accept; first step 4 cycles later; steps every 100 cycles; RUN lasts 10000 cycles; done_o pulses once; step_cnt_o=100; no re-run while cmd_in stays held.
2. Re-arm: after scenario 1, cmd_in=0 for 1 cycle then the same command again → a second full run; step_cnt_o=100.
3. Abort: cmd_in={0,50,20} (dir=0), drop to 0 at cycle 3000 of RUN → IDLE next cycle; no done_o; step_cnt_o=15; motor_en_o=0.
4. Mid-run change: during {1,100,10}, switch to {0,200,5} → SETUP re-entered with dir_o=0; step_cnt_o cleared; RUN 5000 cycles; step_cnt_o=100; a single done_o.
5. Overrun: STEP_HIGH_CYC=20, freq=1000 (period 10) → overrun_o=1; each step_o pulse exactly 20 cycles wide.
6. Async reset asserted mid-RUN (between clock edges) → all outputs 0 immediately, FSM=IDLE; after release with the command still held, a new run starts (armed=1).

Source files
------------

// File: rtl/stepper_pulse_gen_pkg.sv
// Command-word field layout and FSM encoding shared by the stepper pulse generator
// and the upstream command converter.
package stepper_pulse_gen_pkg;

    localparam int CMD_W          = 16;
    localparam int CMD_DIR_BIT    = 15;
    localparam int CMD_FREQ_MSB   = 14;
    localparam int CMD_FREQ_LSB   = 5;
    localparam int CMD_LAPSE_MSB  = 4;
    localparam int CMD_LAPSE_LSB  = 0;
    localparam int FREQ_W         = CMD_FREQ_MSB - CMD_FREQ_LSB + 1;
    localparam int LAPSE_W        = CMD_LAPSE_MSB - CMD_LAPSE_LSB + 1;
    localparam int LAPSE_UNIT_DIV = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // A command is runnable only when both its rate and its duration are nonzero.
    function automatic logic cmd_valid(input logic [CMD_W-1:0] cmd);
        return (cmd[CMD_FREQ_MSB:CMD_FREQ_LSB] != '0) &&
               (cmd[CMD_LAPSE_MSB:CMD_LAPSE_LSB] != '0);
    endfunction

endpackage

// File: rtl/stepper_pulse_gen_step_pulse_stretch.sv
// Fixed-width step pulse: a trigger while the pulse is low starts a HIGH_CYC-cycle
// pulse; a trigger while it is high is dropped and flagged, never queued.
module step_pulse_stretch #(
    parameter int HIGH_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic pulse_o,
    output logic start_o,
    output logic drop_o
);

    localparam int CNT_W = (HIGH_CYC > 1) ? $clog2(HIGH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HIGH_CYC - 1);

    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        start_o = trig_i && !pulse_q;
        drop_o  = trig_i && pulse_q;
        if (start_o) begin
            pulse_d = 1'b1;
            cnt_d   = CNT_LOAD;
        end else if (pulse_q) begin
            if (cnt_q == '0) begin
                pulse_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/stepper_pulse_gen.sv
// One wheel's step/dir/enable sequencer: direction setup, then phase-accumulated
// step pulses at freq steps/s for lapse x 0.1 s.
module stepper_pulse_gen #(
    parameter int CLK_HZ        = 100000000,
    parameter int STEP_HIGH_CYC = 1000,
    parameter int DIR_SETUP_CYC = 500
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic [15:0] cmd_in,
    output logic        step_o,
    output logic        dir_o,
    output logic        motor_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] step_cnt_o,
    output logic        overrun_o
);

    import stepper_pulse_gen_pkg::*;

    localparam int TICK_CYC = CLK_HZ / LAPSE_UNIT_DIV;
    localparam int ACC_W    = $clog2(2 * CLK_HZ);
    localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int SET_W    = (DIR_SETUP_CYC > 1) ? $clog2(DIR_SETUP_CYC) : 1;

    localparam logic [ACC_W-1:0] ACC_MOD   = ACC_W'(CLK_HZ);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_CYC - 1);
    localparam logic [SET_W-1:0] SET_LAST  = SET_W'(DIR_SETUP_CYC - 1);

    state_t               state_q, state_d;
    logic [CMD_W-1:0]     latched_q, latched_d;
    logic                 armed_q, armed_d;
    logic                 dir_q, dir_d;
    logic [SET_W-1:0]     setup_q, setup_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [LAPSE_W-1:0]   tick_q, tick_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 step_trig;
    logic                 step_start;
    logic                 step_drop;
    logic [ACC_W-1:0]     acc_sum;
    logic [LAPSE_W-1:0]   lapse_last;

    step_pulse_stretch #(
        .HIGH_CYC (STEP_HIGH_CYC)
    ) u_stretch (
        .clk     (clk_rx),
        .rst     (rst_clk_rx),
        .trig_i  (step_trig),
        .pulse_o (step_o),
        .start_o (step_start),
        .drop_o  (step_drop)
    );

    assign acc_sum    = acc_q + ACC_W'(latched_q[CMD_FREQ_MSB:CMD_FREQ_LSB]);
    assign lapse_last = latched_q[CMD_LAPSE_MSB:CMD_LAPSE_LSB] - LAPSE_W'(1);

    // Command handling outranks the running sequence: any change, abort or invalid
    // word is acted on before termination or step events are considered.
    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        armed_d   = armed_q;
        dir_d     = dir_q;
        setup_d   = setup_q;
        acc_d     = acc_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        step_trig = 1'b0;

        if (cmd_in == '0) armed_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                accept = cmd_valid(cmd_in) && (armed_q || (cmd_in != latched_q));
            end
            ST_SETUP, ST_RUN: begin
                if (!cmd_valid(cmd_in)) begin
                    state_d = ST_IDLE;
                end else if (cmd_in != latched_q) begin
                    accept = 1'b1;
                end else if (state_q == ST_SETUP) begin
                    if (!step_o) begin
                        if (setup_q == SET_LAST) begin
                            state_d   = ST_RUN;
                            step_trig = 1'b1;
                            acc_d     = '0;
                            pre_d     = '0;
                            tick_d    = '0;
                        end else begin
                            setup_d = setup_q + SET_W'(1);
                        end
                    end
                end else if ((pre_q == PRE_LAST) && (tick_q == lapse_last)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (acc_sum >= ACC_MOD) begin
                        acc_d     = acc_sum - ACC_MOD;
                        step_trig = 1'b1;
                    end else begin
                        acc_d = acc_sum;
                    end
                    if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = tick_q + LAPSE_W'(1);
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d   = ST_SETUP;
            latched_d = cmd_in;
            armed_d   = 1'b0;
            dir_d     = cmd_in[CMD_DIR_BIT];
            setup_d   = '0;
        end
    end

    // Step count and overrun describe the current command, so a new accept wipes them.
    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (accept) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end else begin
            if (step_start && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
            if (step_drop) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            state_q   <= ST_IDLE;
            latched_q <= '0;
            armed_q   <= 1'b1;
            dir_q     <= 1'b0;
            setup_q   <= '0;
            acc_q     <= '0;
            pre_q     <= '0;
            tick_q    <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            armed_q   <= armed_d;
            dir_q     <= dir_d;
            setup_q   <= setup_d;
            acc_q     <= acc_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            done_q    <= done_d;
        end
    end

    assign dir_o      = dir_q;
    assign motor_en_o = (state_q != ST_IDLE);
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign step_cnt_o = cnt_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: two wheels share one command word (narrow and wide
// step pulses), both compared every cycle against a timeline model of the sequence.
module tb_stepper_pulse_gen;

    localparam int TB_CLK_HZ = 10000;
    localparam int TB_TICK   = TB_CLK_HZ / 10;
    localparam int TB_SETUP  = 4;
    localparam int HIGH_A    = 2;
    localparam int HIGH_B    = 20;

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx = 1'b1;
    logic [15:0] cmd_in = 16'h0;

    logic        step_a, dir_a, en_a, busy_a, done_a, ovr_a;
    logic [15:0] cnt_a;
    logic        step_b, dir_b, en_b, busy_b, done_b, ovr_b;
    logic [15:0] cnt_b;
    logic [21:0] outs_a, outs_b;

    assign outs_a = {step_a, dir_a, en_a, busy_a, done_a, ovr_a, cnt_a};
    assign outs_b = {step_b, dir_b, en_b, busy_b, done_b, ovr_b, cnt_b};

    always #5 clk_rx = ~clk_rx;

    stepper_pulse_gen #(
        .CLK_HZ        (TB_CLK_HZ),
        .STEP_HIGH_CYC (HIGH_A),
        .DIR_SETUP_CYC (TB_SETUP)
    ) dut_a (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .cmd_in     (cmd_in),
        .step_o     (step_a),
        .dir_o      (dir_a),
        .motor_en_o (en_a),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .step_cnt_o (cnt_a),
        .overrun_o  (ovr_a)
    );

    stepper_pulse_gen #(
        .CLK_HZ        (TB_CLK_HZ),
        .STEP_HIGH_CYC (HIGH_B),
        .DIR_SETUP_CYC (TB_SETUP)
    ) dut_b (
        .clk_rx     (clk_rx),
        .rst_clk_rx (rst_clk_rx),
        .cmd_in     (cmd_in),
        .step_o     (step_b),
        .dir_o      (dir_b),
        .motor_en_o (en_b),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .step_cnt_o (cnt_b),
        .overrun_o  (ovr_b)
    );

    // Model state: mode 0 idle, 1 direction setup, 2 running; k is the cycle index
    // within the run, hi_left the remaining high cycles of the current step pulse.
    typedef struct {
        int          mode;
        logic [15:0] lat;
        bit          armed;
        bit          dir;
        int          setup_done;
        longint      k;
        int          hi_left;
        int          cnt;
        bit          ovr;
        bit          done;
    } model_t;

    model_t m_a, m_b;
    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int done_cnt = 0;
    int hi_run_b = 0;
    int pulses_b = 0;
    int badw_b = 0;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0; r.lat = 16'h0; r.armed = 1'b1; r.dir = 1'b0; r.setup_done = 0;
        r.k = 0; r.hi_left = 0; r.cnt = 0; r.ovr = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    // Steps fall where floor(t*freq/CLK_HZ) increments over the run timeline.
    function automatic model_t model_next(input model_t m, input logic [15:0] cmd, input int high_cyc);
        model_t n;
        bit valid, req, take;
        longint total, fl;
        n = m; n.done = 1'b0; req = 1'b0; take = 1'b0;
        valid = (cmd[14:5] != 10'd0) && (cmd[4:0] != 5'd0);
        if (m.hi_left > 0) n.hi_left = m.hi_left - 1;
        if (cmd == 16'h0) n.armed = 1'b1;
        if (m.mode == 0) begin
            take = valid && (m.armed || (cmd != m.lat));
        end else if (!valid) begin
            n.mode = 0;
        end else if (cmd != m.lat) begin
            take = 1'b1;
        end else if (m.mode == 1) begin
            if (m.hi_left == 0) begin
                n.setup_done = m.setup_done + 1;
                if (n.setup_done == TB_SETUP) begin
                    n.mode = 2; n.k = 0; req = 1'b1;
                end
            end
        end else begin
            total = longint'(m.lat[4:0]) * TB_TICK;
            fl = longint'(m.lat[14:5]);
            if (m.k == total - 1) begin
                n.mode = 0; n.done = 1'b1;
            end else begin
                if (((m.k + 1) * fl) / TB_CLK_HZ != (m.k * fl) / TB_CLK_HZ) req = 1'b1;
                n.k = m.k + 1;
            end
        end
        if (take) begin
            n.lat = cmd; n.armed = 1'b0; n.dir = cmd[15]; n.mode = 1;
            n.setup_done = 0; n.cnt = 0; n.ovr = 1'b0;
        end
        if (req) begin
            if (m.hi_left > 0) begin
                n.ovr = 1'b1;
            end else begin
                n.hi_left = high_cyc;
                if (n.cnt < 65535) n.cnt = n.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [21:0] model_outs(input model_t m);
        return {m.hi_left > 0, m.dir, m.mode != 0, m.mode != 0, m.done, m.ovr, 16'(m.cnt)};
    endfunction

    function automatic logic [15:0] mk_cmd(input int d, input int f, input int l);
        logic [31:0] dv, fv, lv;
        dv = d; fv = f; lv = l;
        return {dv[0], fv[9:0], lv[4:0]};
    endfunction

    always @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            m_a <= model_reset();
            m_b <= model_reset();
        end else begin
            m_a <= model_next(m_a, cmd_in, HIGH_A);
            m_b <= model_next(m_b, cmd_in, HIGH_B);
        end
    end

    task automatic check_val(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkOutput();
        logic [21:0] exp_a, exp_b;
        exp_a = model_outs(m_a);
        exp_b = model_outs(m_b);
        checks += 2;
        if (outs_a !== exp_a) begin
            failures++;
            $display("[TB] FAIL model_wheel_a: got %h expected %h (cycle %0d)", outs_a, exp_a, cycle);
        end
        if (outs_b !== exp_b) begin
            failures++;
            $display("[TB] FAIL model_wheel_b: got %h expected %h (cycle %0d)", outs_b, exp_b, cycle);
        end
    endtask

    task automatic tick();
        @(negedge clk_rx);
        cycle++;
        checkOutput();
        if (done_a) done_cnt++;
        if (step_b) begin
            hi_run_b++;
        end else if (hi_run_b != 0) begin
            pulses_b++;
            if (hi_run_b != HIGH_B) badw_b++;
            hi_run_b = 0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] c);
        cmd_in = c;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = 0;
        for (int i = 1; i <= budget && at == 0; i++) begin
            tick();
            if (done_a) at = i;
        end
    endtask

    task automatic wait_step(input int budget, output int at);
        at = 0;
        for (int i = 1; i <= budget && at == 0; i++) begin
            tick();
            if (step_a) at = i;
        end
    endtask

    logic [15:0] cmd_a;
    logic [15:0] rnd_cmd;
    int at, d0, sel;

    initial begin
        cmd_a = mk_cmd(1, 100, 10);
        repeat (3) tick();
        check_val("reset_outputs_a", outs_a, 0);
        check_val("reset_outputs_b", outs_b, 0);
        rst_clk_rx = 1'b0;
        tick();

        $display("[TB] basic run");
        d0 = done_cnt;
        applyStimulus(cmd_a);
        at = 0;
        for (int i = 1; i <= 12000 && at == 0; i++) begin
            tick();
            if (i == 1) begin
                check_val("s1_dir_after_accept", dir_a, 1);
                check_val("s1_busy_in_setup", busy_a, 1);
            end
            if (i == 4) check_val("s1_no_step_during_setup", step_a, 0);
            if (i == 5) check_val("s1_first_step", step_a, 1);
            if (done_a) at = i;
        end
        check_val("s1_done_cycle", at, 10005);
        check_val("s1_step_cnt", cnt_a, 100);
        repeat (200) tick();
        check_val("s1_no_rerun", busy_a, 0);
        check_val("s1_single_done", done_cnt - d0, 1);

        $display("[TB] re-arm");
        applyStimulus(16'h0);
        tick();
        applyStimulus(cmd_a);
        wait_done(12000, at);
        check_val("s2_done_cycle", at, 10005);
        check_val("s2_step_cnt", cnt_a, 100);

        $display("[TB] abort");
        applyStimulus(16'h0);
        tick();
        d0 = done_cnt;
        applyStimulus(mk_cmd(0, 50, 20));
        wait_step(20, at);
        check_val("s3_run_entry", at, 5);
        check_val("s3_dir", dir_a, 0);
        repeat (2999) tick();
        applyStimulus(16'h0);
        tick();
        check_val("s3_motor_en_off", en_a, 0);
        check_val("s3_step_cnt", cnt_a, 15);
        check_val("s3_no_done", done_cnt - d0, 0);

        $display("[TB] mid-run change");
        applyStimulus(cmd_a);
        wait_step(20, at);
        repeat (1234) tick();
        d0 = done_cnt;
        applyStimulus(mk_cmd(0, 200, 5));
        tick();
        check_val("s4_dir_updated", dir_a, 0);
        check_val("s4_cnt_cleared", cnt_a, 0);
        check_val("s4_busy", busy_a, 1);
        wait_done(8000, at);
        check_val("s4_done_cycle", at, 5004);
        check_val("s4_step_cnt", cnt_a, 100);
        check_val("s4_single_done", done_cnt - d0, 1);

        $display("[TB] overrun");
        applyStimulus(16'h0);
        repeat (2) tick();
        pulses_b = 0;
        badw_b = 0;
        applyStimulus(mk_cmd(1, 1000, 1));
        wait_done(2000, at);
        check_val("s5_done_cycle", at, 1005);
        repeat (30) tick();
        check_val("s5_overrun_wide", ovr_b, 1);
        check_val("s5_no_overrun_narrow", ovr_a, 0);
        check_val("s5_cnt_wide", cnt_b, 34);
        check_val("s5_cnt_narrow", cnt_a, 100);
        check_val("s5_pulse_count_wide", pulses_b, 34);
        check_val("s5_bad_widths", badw_b, 0);

        $display("[TB] async reset");
        applyStimulus(cmd_a);
        wait_step(20, at);
        repeat (500) tick();
        #2 rst_clk_rx = 1'b1;
        #1;
        check_val("s6_async_clear_a", outs_a, 0);
        check_val("s6_async_clear_b", outs_b, 0);
        tick();
        tick();
        rst_clk_rx = 1'b0;
        wait_step(20, at);
        check_val("s6_restart_entry", at, 5);
        check_val("s6_restart_dir", dir_a, 1);

        $display("[TB] random commands");
        for (int r = 0; r < 14; r++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                rnd_cmd = 16'h0;
            end else if (sel == 2) begin
                rnd_cmd = mk_cmd($urandom_range(0, 1), 0, $urandom_range(1, 31));
            end else if (sel == 3) begin
                rnd_cmd = cmd_in;
            end else begin
                rnd_cmd = mk_cmd($urandom_range(0, 1), $urandom_range(1, 1023), $urandom_range(1, 2));
            end
            applyStimulus(rnd_cmd);
            repeat ($urandom_range(1, 1500)) tick();
        end
        applyStimulus(16'h0);
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
